// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches
// that consume its line.
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int                   SEQ_PAT_W    = 6;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN  = 6'b001001;
  localparam logic                 SEQ_IDLE_BIT = 1'b1;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first, rep_cnt times, with gap_len
// idle cycles between repetitions and a ready handshake on every bit.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int               PAT_W    = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN  = SEQ_PATTERN,
  parameter int               CNT_W    = 4,
  parameter int               GAP_W    = 4,
  parameter logic             IDLE_BIT = SEQ_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  input  logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  state_e           state_q,   state_d;
  logic [PAT_W-1:0] shreg_q,   shreg_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [CNT_W-1:0] rep_q,     rep_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic             dout_q,    dout_d;
  logic             valid_q,   valid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_len_d = gap_len_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (abort) begin
      // Abort also swallows a start that arrives in the same cycle.
      state_d = ST_IDLE;
      idx_d   = '0;
      rep_d   = '0;
      gap_d   = '0;
      dout_d  = IDLE_BIT;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (rep_cnt == '0) begin
              done_d = 1'b1;
            end else begin
              state_d   = ST_SHIFT;
              rep_d     = rep_cnt;
              gap_len_d = gap_len;
              shreg_d   = PATTERN;
              idx_d     = '0;
              dout_d    = PATTERN[PAT_W-1];
              valid_d   = 1'b1;
              busy_d    = 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          if (ready) begin
            if (idx_q != LAST_IDX) begin
              shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
              dout_d  = shreg_q[PAT_W-2];
              idx_d   = idx_q + 1'b1;
            end else begin
              rep_d = rep_q - 1'b1;
              if (rep_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                dout_d  = IDLE_BIT;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else if (gap_len_q == '0) begin
                // Back-to-back repetition: reload without a valid bubble.
                shreg_d = PATTERN;
                idx_d   = '0;
                dout_d  = PATTERN[PAT_W-1];
              end else begin
                state_d = ST_GAP;
                idx_d   = '0;
                gap_d   = gap_len_q;
                dout_d  = IDLE_BIT;
                valid_d = 1'b0;
              end
            end
          end
        end

        ST_GAP: begin
          // Gap runs on cycles alone; ready has no effect while no bit is offered.
          if (gap_q == GAP_W'(1)) begin
            state_d = ST_SHIFT;
            gap_d   = '0;
            shreg_d = PATTERN;
            idx_d   = '0;
            dout_d  = PATTERN[PAT_W-1];
            valid_d = 1'b1;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          dout_d  = IDLE_BIT;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_len_q <= '0;
      dout_q    <= IDLE_BIT;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_len_q <= gap_len_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: hand-computed bit streams, burst lengths
// and completion timing for the default 001001 pattern.
module tb_seq_pattern_tx;

  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
  logic             ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] bits;
  int nbits, nbusy, ngap, ngap_idle, nhold, done_c, end_c, first_v;

  seq_pattern_tx #(
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rep_cnt    (rep_cnt),
    .gap_len    (gap_len),
    .abort      (abort),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start, then watch the line cycle by cycle (cycle 1 = first cycle after
  // the start edge) until done or the line drops out of busy.
  task automatic run_burst(input int rc, input int gl, input int stall_c,
                           input int stall_n, input int abort_c, input int extra_c);
    bits = '0; nbits = 0; nbusy = 0; ngap = 0; ngap_idle = 0; nhold = 0;
    done_c = 0; end_c = 0; first_v = 0;
    rep_cnt = CNT_W'(rc);
    gap_len = GAP_W'(gl);
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      ready = !(c >= stall_c && c < stall_c + stall_n);
      abort = (c == abort_c);
      start = (c == extra_c);
      if (start) rep_cnt = CNT_W'(3);
      if (busy) nbusy++;
      if (dout_valid && first_v == 0) first_v = c;
      if (dout_valid && ready) begin
        bits = {bits[62:0], dout};
        nbits++;
      end
      if (dout_valid && !ready && dout) nhold++;
      if (busy && !dout_valid) begin
        ngap++;
        if (dout) ngap_idle++;
      end
      if (done || !busy) begin
        done_c = done ? c : 0;
        end_c  = c;
        break;
      end
      step();
    end
    ready = 1'b1;
    abort = 1'b0;
    start = 1'b0;
    if (end_c == 0) check_eq("burst_timeout", end_c, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rep_cnt = '0; gap_len = '0; abort = 1'b0; ready = 1'b1;
    #12;
    check_eq("rst_dout", dout, 1);
    check_eq("rst_valid", dout_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single repetition
    run_burst(1, 0, 0, 0, 0, 0);
    check_eq("r1_bits", bits, 64'b001001);
    check_eq("r1_nbits", nbits, 6);
    check_eq("r1_first", first_v, 1);
    check_eq("r1_busy", nbusy, 6);
    check_eq("r1_done", done_c, 7);

    // Three repetitions with a 2-cycle gap
    run_burst(3, 2, 0, 0, 0, 0);
    check_eq("r3g2_bits", bits, 64'b001001001001001001);
    check_eq("r3g2_nbits", nbits, 18);
    check_eq("r3g2_gap", ngap, 4);
    check_eq("r3g2_gapidle", ngap_idle, 4);
    check_eq("r3g2_busy", nbusy, 22);
    check_eq("r3g2_done", done_c, 23);

    // Started in the done cycle of the previous burst; back-to-back repetitions
    run_burst(2, 0, 0, 0, 0, 0);
    check_eq("r2g0_first", first_v, 1);
    check_eq("r2g0_bits", bits, 64'b001001001001);
    check_eq("r2g0_bubble", ngap, 0);
    check_eq("r2g0_busy", nbusy, 12);
    check_eq("r2g0_done", done_c, 13);
    step();

    // ready low for 3 cycles while the third bit (a 1) is offered
    run_burst(1, 0, 3, 3, 0, 0);
    check_eq("stall_bits", bits, 64'b001001);
    check_eq("stall_nbits", nbits, 6);
    check_eq("stall_hold", nhold, 3);
    check_eq("stall_bubble", ngap, 0);
    check_eq("stall_done", done_c, 10);
    step();

    // Zero repetitions
    run_burst(0, 5, 0, 0, 0, 0);
    check_eq("r0_done", done_c, 1);
    check_eq("r0_valid", first_v, 0);
    check_eq("r0_busy", nbusy, 0);
    step();

    // A second start mid-burst is ignored
    run_burst(1, 0, 0, 0, 0, 3);
    check_eq("restart_nbits", nbits, 6);
    check_eq("restart_bits", bits, 64'b001001);
    check_eq("restart_done", done_c, 7);
    step();
    check_eq("restart_idle", busy, 0);

    // Abort while bit index 3 is offered
    run_burst(2, 0, 0, 0, 4, 0);
    check_eq("abort_end", end_c, 5);
    check_eq("abort_nodone", done_c, 0);
    check_eq("abort_valid", dout_valid, 0);
    check_eq("abort_dout", dout, 1);
    step();
    check_eq("abort_done_after", done, 0);

    // Abort and start together in IDLE
    rep_cnt = CNT_W'(1); start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_eq("abstart_busy", busy, 0);
    check_eq("abstart_valid", dout_valid, 0);
    check_eq("abstart_done", done, 0);
    step();
    check_eq("abstart_busy2", busy, 0);

    // Asynchronous reset mid-burst, then a clean burst afterwards
    rep_cnt = CNT_W'(2); gap_len = '0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("prerst_busy", busy, 1);
    check_eq("prerst_dout", dout, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_dout", dout, 1);
    check_eq("arst_valid", dout_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_burst(1, 0, 0, 0, 0, 0);
    check_eq("postrst_bits", bits, 64'b001001);
    check_eq("postrst_done", done_c, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
